// File: rtl/spi_slave_port_pkg.sv
// Shared definitions for the SPI slave port: FSM state type, SPI mode and
// default frame width.
package spi_slave_port_pkg;

    localparam int SPI_DATA_W = 32'd8;

    // {CPOL, CPHA}; mode 0 idles SCLK low and samples on the rising edge
    localparam logic [1:0] SPI_MODE = 2'b00;

    typedef enum logic {
        ST_IDLE   = 1'b0,
        ST_ACTIVE = 1'b1
    } spi_state_e;

endpackage

// File: rtl/spi_slave_port_if.sv
// SPI pins plus the parallel transmit/receive side of one slave slot.
interface spi_slave_port_if #(
    parameter int DATA_W = 32'd8
);
    logic              sclk;
    logic              mosi;
    logic              ss_n;
    logic              miso;
    logic [DATA_W-1:0] tx_data;
    logic              tx_valid;
    logic              tx_ready;
    logic [DATA_W-1:0] rx_data;
    logic              rx_valid;
    logic              tx_underrun;
    logic              frame_err;

    modport slave (
        input  sclk, mosi, ss_n, tx_data, tx_valid,
        output miso, tx_ready, rx_data, rx_valid, tx_underrun, frame_err
    );

    modport master (
        output sclk, mosi, ss_n, tx_data, tx_valid,
        input  miso, tx_ready, rx_data, rx_valid, tx_underrun, frame_err
    );
endinterface

// File: rtl/spi_slave_port_sync_edge.sv
// Two-flop synchroniser for an asynchronous pin with registered rise/fall
// strobes; the strobes appear three clocks after the pin edge.
module spi_sync_edge #(
    parameter logic RST_VAL = 1'b0
) (
    input  logic clk,
    input  logic rst_n,
    input  logic din,
    output logic sync,
    output logic rise,
    output logic fall
);
    logic meta_r;
    logic sync_r;
    logic prev_r;
    logic rise_r;
    logic fall_r;

    // Synchroniser chain, delayed copy and edge strobes
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta_r <= RST_VAL;
            sync_r <= RST_VAL;
            prev_r <= RST_VAL;
            rise_r <= 1'b0;
            fall_r <= 1'b0;
        end else begin
            meta_r <= din;
            sync_r <= meta_r;
            prev_r <= sync_r;
            rise_r <= sync_r & ~prev_r;
            fall_r <= ~sync_r & prev_r;
        end
    end

    assign sync = sync_r;
    assign rise = rise_r;
    assign fall = fall_r;
endmodule

// File: rtl/spi_slave_port.sv
// spi_slave_port: mode-0 SPI responder with oversampled pins, a one-entry
// transmit holding register and a parallel receive word.
module spi_slave_port
    import spi_slave_port_pkg::*;
#(
    parameter int                DATA_W  = SPI_DATA_W,
    parameter logic [DATA_W-1:0] IDLE_TX = {DATA_W{1'b0}}
) (
    input  logic            clk,
    input  logic            rst_n,
    spi_slave_port_if.slave bus
);
    localparam int               CNT_W    = $clog2(DATA_W) + 32'd1;
    localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(32'd1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DATA_W - 32'd1);

    logic sclk_rise_s, sclk_fall_s, sclk_level_unused_s;
    logic ss_rise_s, ss_fall_s, ss_level_unused_s;
    logic mosi_sync_s, mosi_rise_unused_s, mosi_fall_unused_s;

    // ss_n resets to "selected" so a frame already running at reset release
    // produces no falling edge and is ignored until ss_n cycles.
    spi_sync_edge #(.RST_VAL(SPI_MODE[1])) u_sclk_sync (
        .clk(clk), .rst_n(rst_n), .din(bus.sclk),
        .sync(sclk_level_unused_s), .rise(sclk_rise_s), .fall(sclk_fall_s)
    );
    spi_sync_edge #(.RST_VAL(1'b0)) u_ss_sync (
        .clk(clk), .rst_n(rst_n), .din(bus.ss_n),
        .sync(ss_level_unused_s), .rise(ss_rise_s), .fall(ss_fall_s)
    );
    spi_sync_edge #(.RST_VAL(1'b0)) u_mosi_sync (
        .clk(clk), .rst_n(rst_n), .din(bus.mosi),
        .sync(mosi_sync_s), .rise(mosi_rise_unused_s), .fall(mosi_fall_unused_s)
    );

    spi_state_e        state_r;
    logic [CNT_W-1:0]  bit_cnt_r;
    logic [DATA_W-1:0] tx_shift_r;
    logic [DATA_W-1:0] rx_shift_r;
    logic [DATA_W-1:0] hold_r;
    logic [DATA_W-1:0] rx_data_r;
    logic              hold_full_r;
    logic              tx_ready_r;
    logic              miso_r;
    logic              rx_valid_r;
    logic              tx_underrun_r;
    logic              frame_err_r;

    logic              tx_write_s;
    logic              load_s;
    logic              hold_next_s;
    logic [DATA_W-1:0] load_word_s;

    // Frame-start decision: select falling in IDLE, or a falling SCLK at a frame boundary
    always_comb begin
        load_s = 1'b0;
        case (state_r)
            ST_IDLE: begin
                load_s = ss_fall_s;
            end
            ST_ACTIVE: begin
                if (ss_rise_s) begin
                    load_s = 1'b0;
                end else begin
                    load_s = sclk_fall_s && (bit_cnt_r == CNT_ZERO);
                end
            end
            default: begin
                load_s = 1'b0;
            end
        endcase
    end

    assign tx_write_s  = bus.tx_valid && tx_ready_r;
    assign hold_next_s = tx_write_s || (hold_full_r && !load_s);
    assign load_word_s = hold_full_r ? hold_r : IDLE_TX;

    // Holding register, frame FSM, shift registers and status pulses
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r       <= ST_IDLE;
            bit_cnt_r     <= CNT_ZERO;
            tx_shift_r    <= {DATA_W{1'b0}};
            rx_shift_r    <= {DATA_W{1'b0}};
            hold_r        <= {DATA_W{1'b0}};
            rx_data_r     <= {DATA_W{1'b0}};
            hold_full_r   <= 1'b0;
            tx_ready_r    <= 1'b1;
            miso_r        <= 1'b0;
            rx_valid_r    <= 1'b0;
            tx_underrun_r <= 1'b0;
            frame_err_r   <= 1'b0;
        end else begin
            rx_valid_r    <= 1'b0;
            frame_err_r   <= 1'b0;
            tx_underrun_r <= load_s && !hold_full_r;
            hold_full_r   <= hold_next_s;
            tx_ready_r    <= !hold_next_s;
            if (tx_write_s) begin
                hold_r <= bus.tx_data;
            end
            case (state_r)
                ST_IDLE: begin
                    bit_cnt_r <= CNT_ZERO;
                    if (ss_fall_s) begin
                        state_r    <= ST_ACTIVE;
                        tx_shift_r <= load_word_s;
                        miso_r     <= load_word_s[DATA_W-1];
                    end else begin
                        miso_r <= 1'b0;
                    end
                end
                ST_ACTIVE: begin
                    if (ss_rise_s) begin
                        state_r    <= ST_IDLE;
                        miso_r     <= 1'b0;
                        bit_cnt_r  <= CNT_ZERO;
                        rx_shift_r <= {DATA_W{1'b0}};
                        frame_err_r <= (bit_cnt_r != CNT_ZERO);
                    end else if (sclk_rise_s) begin
                        rx_shift_r <= {rx_shift_r[DATA_W-2:0], mosi_sync_s};
                        if (bit_cnt_r == CNT_LAST) begin
                            rx_data_r  <= {rx_shift_r[DATA_W-2:0], mosi_sync_s};
                            rx_valid_r <= 1'b1;
                            bit_cnt_r  <= CNT_ZERO;
                        end else begin
                            bit_cnt_r <= bit_cnt_r + CNT_ONE;
                        end
                    end else if (sclk_fall_s) begin
                        if (bit_cnt_r != CNT_ZERO) begin
                            tx_shift_r <= {tx_shift_r[DATA_W-2:0], 1'b0};
                            miso_r     <= tx_shift_r[DATA_W-2];
                        end else begin
                            tx_shift_r <= load_word_s;
                            miso_r     <= load_word_s[DATA_W-1];
                        end
                    end else begin
                        bit_cnt_r <= bit_cnt_r;
                    end
                end
                default: begin
                    state_r <= ST_IDLE;
                    miso_r  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.miso        = miso_r;
    assign bus.tx_ready    = tx_ready_r;
    assign bus.rx_data     = rx_data_r;
    assign bus.rx_valid    = rx_valid_r;
    assign bus.tx_underrun = tx_underrun_r;
    assign bus.frame_err   = frame_err_r;
endmodule

// File: tb/tb_spi_slave_port.sv
// Bench for spi_slave_port: a transaction-level model applies each pin edge
// four clocks after it is driven and is compared against the DUT every cycle.
module tb_spi_slave_port;
    localparam int         DW      = 8;
    localparam logic [7:0] IDLE_TX = 8'h00;
    localparam int         EVN     = 8192;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    spi_slave_port_if #(.DATA_W(DW)) tif();

    spi_slave_port #(.DATA_W(DW), .IDLE_TX(IDLE_TX)) dut (
        .clk(clk), .rst_n(rst_n), .bus(tif)
    );

    int n_checks = 0;
    int n_errors = 0;
    int cyc = 0;

    // Pin events, indexed by the clock at which they take effect
    logic ev_ss_fall [EVN];
    logic ev_ss_rise [EVN];
    logic ev_rise    [EVN];
    logic ev_fall    [EVN];
    logic ev_mosi    [EVN];

    // Model state
    logic       m_active, m_hold_full, m_tx_ready, m_miso;
    logic       m_rx_valid, m_und, m_ferr;
    logic [7:0] m_hold, m_word, m_rx, m_rx_data;
    int         m_bits;

    // Counters of observed DUT pulses and the log of received words
    int         n_rxv = 0, n_und = 0, n_ferr = 0;
    logic [7:0] rx_log [$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            if (n_errors <= 40)
                $display("FAIL %s at cycle %0d: got %0h expected %0h", name, cyc, act, exp);
        end
    endtask

    task automatic m_reset();
        m_active = 1'b0; m_hold_full = 1'b0; m_tx_ready = 1'b1; m_miso = 1'b0;
        m_rx_valid = 1'b0; m_und = 1'b0; m_ferr = 1'b0;
        m_hold = 8'h00; m_word = 8'h00; m_rx = 8'h00; m_rx_data = 8'h00; m_bits = 0;
    endtask

    task automatic m_step();
        logic       wr, load;
        logic [7:0] wd;
        wr = tif.tx_valid && m_tx_ready;
        wd = tif.tx_data;
        load = 1'b0;
        m_rx_valid = 1'b0; m_und = 1'b0; m_ferr = 1'b0;
        if (cyc < EVN) begin
            if (ev_ss_rise[cyc]) begin
                if (m_active) begin
                    m_ferr = (m_bits != 0);
                    m_active = 1'b0; m_bits = 0; m_miso = 1'b0;
                end
            end else if (ev_ss_fall[cyc]) begin
                if (!m_active) begin
                    m_active = 1'b1; load = 1'b1;
                end
            end else if (m_active && ev_rise[cyc]) begin
                m_rx = {m_rx[6:0], ev_mosi[cyc]};
                m_bits++;
                if (m_bits == DW) begin
                    m_rx_data = m_rx; m_rx_valid = 1'b1; m_bits = 0;
                end
            end else if (m_active && ev_fall[cyc]) begin
                if (m_bits != 0) m_miso = m_word[7 - m_bits];
                else load = 1'b1;
            end
        end
        if (load) begin
            m_word = m_hold_full ? m_hold : IDLE_TX;
            m_und  = !m_hold_full;
            m_miso = m_word[7];
        end
        m_hold_full = (m_hold_full && !load) || wr;
        if (wr) m_hold = wd;
        m_tx_ready = !m_hold_full;
    endtask

    // Model step on every clock, then compare all DUT outputs
    initial begin : compare
        m_reset();
        forever begin
            @(posedge clk);
            cyc = cyc + 1;
            if (!rst_n) begin
                m_reset();
                for (int i = cyc; i < EVN; i++) begin
                    ev_ss_fall[i] = 1'b0; ev_ss_rise[i] = 1'b0;
                    ev_rise[i] = 1'b0; ev_fall[i] = 1'b0;
                end
            end else begin
                m_step();
            end
            #1;
            chk("miso", {31'd0, tif.miso}, {31'd0, m_miso});
            chk("tx_ready", {31'd0, tif.tx_ready}, {31'd0, m_tx_ready});
            chk("rx_data", {24'd0, tif.rx_data}, {24'd0, m_rx_data});
            chk("rx_valid", {31'd0, tif.rx_valid}, {31'd0, m_rx_valid});
            chk("tx_underrun", {31'd0, tif.tx_underrun}, {31'd0, m_und});
            chk("frame_err", {31'd0, tif.frame_err}, {31'd0, m_ferr});
            if (tif.rx_valid === 1'b1) begin
                n_rxv++;
                rx_log.push_back(tif.rx_data);
            end
            if (tif.tx_underrun === 1'b1) n_und++;
            if (tif.frame_err === 1'b1) n_ferr++;
        end
    end

    task automatic wait_neg(input int n);
        repeat (n) @(negedge clk);
    endtask

    function automatic int ev_idx();
        return (cyc + 4 < EVN) ? cyc + 4 : EVN - 1;
    endfunction

    task automatic ss_set(input logic v);
        tif.ss_n = v;
        if (v) ev_ss_rise[ev_idx()] = 1'b1;
        else   ev_ss_fall[ev_idx()] = 1'b1;
    endtask

    // Master side: MOSI set at the preceding fall, MISO captured at each rise
    task automatic frame(input logic [7:0] mo, input int nbits, output logic [7:0] cap);
        cap = 8'h00;
        for (int i = 0; i < nbits; i++) begin
            tif.mosi = mo[7 - i];
            wait_neg(5);
            tif.sclk = 1'b1;
            ev_rise[ev_idx()] = 1'b1;
            ev_mosi[ev_idx()] = mo[7 - i];
            cap[7 - i] = tif.miso;
            wait_neg(5);
            tif.sclk = 1'b0;
            ev_fall[ev_idx()] = 1'b1;
        end
    endtask

    task automatic tx_write(input logic [7:0] d);
        bit done;
        done = 1'b0;
        tif.tx_valid = 1'b1;
        tif.tx_data  = d;
        for (int i = 0; i < 100 && !done; i++) begin
            if (tif.tx_ready === 1'b1) done = 1'b1;
            @(negedge clk);
        end
        tif.tx_valid = 1'b0;
        if (!done) chk("tx_write_timeout", 32'd0, 32'd1);
    endtask

    initial begin : timeout
        #500000;
        $display("FAIL global_timeout at cycle %0d", cyc);
        $fatal(1, "timeout");
    end

    initial begin : stimulus
        logic [7:0] cap, cap2;
        int         r0, u0, f0;
        for (int i = 0; i < EVN; i++) begin
            ev_ss_fall[i] = 1'b0; ev_ss_rise[i] = 1'b0;
            ev_rise[i] = 1'b0; ev_fall[i] = 1'b0; ev_mosi[i] = 1'b0;
        end
        tif.sclk = 1'b0; tif.mosi = 1'b0; tif.ss_n = 1'b1;
        tif.tx_data = 8'h00; tif.tx_valid = 1'b0;
        wait_neg(4);
        rst_n = 1'b1;
        wait_neg(6);
        chk("rst_miso", {31'd0, tif.miso}, 32'd0);
        chk("rst_tx_ready", {31'd0, tif.tx_ready}, 32'd1);
        chk("rst_rx_data", {24'd0, tif.rx_data}, 32'd0);
        chk("rst_rx_valid", {31'd0, tif.rx_valid}, 32'd0);
        chk("rst_underrun", {31'd0, tif.tx_underrun}, 32'd0);
        chk("rst_frame_err", {31'd0, tif.frame_err}, 32'd0);

        // Basic frame: A5 out, 3C in
        tx_write(8'hA5);
        chk("t1_ready_full", {31'd0, tif.tx_ready}, 32'd0);
        r0 = n_rxv;
        ss_set(1'b0);
        wait_neg(5);
        chk("t1_ready_at_start", {31'd0, tif.tx_ready}, 32'd1);
        frame(8'h3C, 8, cap);
        ss_set(1'b1);
        wait_neg(8);
        chk("t1_miso_word", {24'd0, cap}, 32'h0000_00A5);
        chk("t1_rx_data", {24'd0, tif.rx_data}, 32'h0000_003C);
        chk("t1_rx_pulses", n_rxv - r0, 32'd1);

        // Underrun frame
        u0 = n_und;
        ss_set(1'b0);
        wait_neg(5);
        chk("t2_underrun_at_ss", n_und - u0, 32'd1);
        frame(8'hC7, 8, cap);
        ss_set(1'b1);
        wait_neg(8);
        chk("t2_miso_word", {24'd0, cap}, 32'h0000_0000);
        chk("t2_rx_data", {24'd0, tif.rx_data}, 32'h0000_00C7);

        // Back-to-back frames within one select
        tx_write(8'h81);
        r0 = n_rxv;
        ss_set(1'b0);
        tx_write(8'h7E);
        frame(8'h12, 8, cap);
        frame(8'h34, 8, cap2);
        ss_set(1'b1);
        wait_neg(8);
        chk("t3_miso_word1", {24'd0, cap}, 32'h0000_0081);
        chk("t3_miso_word2", {24'd0, cap2}, 32'h0000_007E);
        chk("t3_rx_pulses", n_rxv - r0, 32'd2);
        if (rx_log.size() >= 2) begin
            chk("t3_rx_first", {24'd0, rx_log[rx_log.size() - 2]}, 32'h0000_0012);
            chk("t3_rx_second", {24'd0, rx_log[rx_log.size() - 1]}, 32'h0000_0034);
        end else begin
            chk("t3_rx_log_size", rx_log.size(), 32'd2);
        end

        // Partial frame: select released after 5 bits
        tx_write(8'hFF);
        r0 = n_rxv; f0 = n_ferr;
        ss_set(1'b0);
        frame(8'hF0, 5, cap);
        chk("t4_miso_high", {31'd0, tif.miso}, 32'd1);
        ss_set(1'b1);
        wait_neg(4);
        chk("t4_miso_low", {31'd0, tif.miso}, 32'd0);
        chk("t4_frame_err", n_ferr - f0, 32'd1);
        wait_neg(6);
        chk("t4_no_rx_valid", n_rxv - r0, 32'd0);
        chk("t4_rx_kept", {24'd0, tif.rx_data}, 32'h0000_0034);

        // Write pending while the full register is consumed at frame start
        tx_write(8'hC3);
        ss_set(1'b0);
        tx_write(8'h5A);
        chk("t5_ready_refilled", {31'd0, tif.tx_ready}, 32'd0);
        frame(8'h55, 8, cap);
        frame(8'hAA, 8, cap2);
        ss_set(1'b1);
        wait_neg(8);
        chk("t5_old_word", {24'd0, cap}, 32'h0000_00C3);
        chk("t5_new_word", {24'd0, cap2}, 32'h0000_005A);
        chk("t5_rx_data", {24'd0, tif.rx_data}, 32'h0000_00AA);

        // Reset at bit 3, release with select still low
        ss_set(1'b0);
        frame(8'h96, 3, cap);
        rst_n = 1'b0;
        wait_neg(3);
        chk("t6_rst_miso", {31'd0, tif.miso}, 32'd0);
        chk("t6_rst_tx_ready", {31'd0, tif.tx_ready}, 32'd1);
        chk("t6_rst_rx_data", {24'd0, tif.rx_data}, 32'd0);
        rst_n = 1'b1;
        r0 = n_rxv;
        frame(8'hFF, 5, cap);
        ss_set(1'b1);
        wait_neg(8);
        chk("t6_no_rx_valid", n_rxv - r0, 32'd0);
        chk("t6_rx_data_clear", {24'd0, tif.rx_data}, 32'd0);
        ss_set(1'b0);
        frame(8'h69, 8, cap);
        ss_set(1'b1);
        wait_neg(8);
        chk("t6_new_frame_rx", {24'd0, tif.rx_data}, 32'h0000_0069);
        chk("t6_new_frame_pulses", n_rxv - r0, 32'd1);
        chk("t6_new_frame_miso", {24'd0, cap}, 32'h0000_0000);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule

// File: doc/spi_slave_port.md
# spi_slave_port

Synchronous SPI responder, mode 0 (CPOL=0, CPHA=0), MSB first: one instance per slave slot, driving the per-slot MISO line that the master-side slave-select multiplexer returns to the master. It oversamples SCLK, MOSI and its own active-low select on the system clock, deserialises received frames into a parallel word, and serialises a word offered through a one-entry valid/ready transmit buffer. Back-to-back frames within one select assertion are supported.

## Interface
- DATA_W, 8: frame width in bits.
- IDLE_TX, 8'h00: word shifted out when no transmit word is buffered at frame start. Width DATA_W.
- clk  in  1  system clock; all logic is on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- sclk  in  1  SPI clock from master, asynchronous to clk.
- mosi  in  1  master-out data, asynchronous.
- ss_n  in  1  this slot's select, active low, asynchronous.
- miso  out  1  slave-out data; driven 0 while deselected (no tristate).
- tx_data  in  DATA_W  word to transmit.
- tx_valid  in  1  tx_data offered.
- tx_ready  out  1  transmit holding register empty.
- rx_data  out  DATA_W  last complete received word.
- rx_valid  out  1  one-cycle pulse: rx_data updated.
- tx_underrun  out  1  one-cycle pulse: frame started with empty holding register.
- frame_err  out  1  one-cycle pulse: ss_n deasserted with a partial frame.

## Operation
- sclk, mosi, ss_n each pass through a 2-flop synchroniser; a third flop on sclk and ss_n gives edge detection (sclk_rise, sclk_fall, ss_fall, ss_rise).
- Holding register: written when tx_valid && tx_ready; tx_ready = !hold_full. Consuming and writing in the same cycle is allowed: the load takes the old contents and the new word fills the register.
- States IDLE, ACTIVE.
- IDLE: miso = 0, bit_cnt = 0. On ss_fall: go to ACTIVE; load tx_shift from holding register (clear hold_full) or from IDLE_TX (pulse tx_underrun); miso = tx_shift MSB.
- ACTIVE, sclk_rise: rx_shift <= {rx_shift[DATA_W-2:0], mosi_sync}; bit_cnt++. On the DATA_W-th rise: rx_data <= completed word, rx_valid pulses next cycle, bit_cnt <= 0.
- ACTIVE, sclk_fall: if bit_cnt != 0, shift tx_shift left and present the next bit. If bit_cnt == 0 (frame boundary), reload tx_shift as at frame start, including the tx_underrun rule.
- ACTIVE, ss_rise: go to IDLE. If bit_cnt != 0, pulse frame_err and discard rx_shift; rx_data is unchanged.
- Event priority in one cycle: ss_rise wins over sclk edges. An sclk edge coinciding with ss_fall is ignored.
- Arithmetic: bit_cnt has clog2(DATA_W)+1 bits and wraps to 0 only by explicit clear, never by overflow.

## Timing
- Reset values: miso 0, tx_ready 1, rx_data 0, rx_valid 0, tx_underrun 0, frame_err 0, state IDLE, hold_full 0.
- Input latency: 3 clk from an external pin edge to the internal edge strobe.
- Constraint: f_clk ≥ 8 × f_sclk. The master must leave ≥ 4 clk between ss_n falling and the first sclk rise.
- miso update: ≤ 4 clk after ss_n falling or sclk falling edge.
- rx_valid: asserted 4 clk after the DATA_W-th external sclk rise, exactly one cycle wide.
- Reset mid-frame: all state cleared immediately. After reset release, the block waits for a fresh ss_fall; a frame that is already in progress is ignored until ss_n rises and falls again.

## Structure
- Shared SPI package holds the state enum (IDLE, ACTIVE), the mode-0 constant, and the default DATA_W.
- Sub-module spi_sync_edge: 2-flop synchroniser plus edge detector with outputs sync, rise and fall. It is instantiated once each for sclk and ss_n; mosi uses its sync output only.

## Test plan
- Load tx 8'hA5 and run one frame with MOSI 8'h3C: the master captures 8'hA5 on MISO, rx_data = 8'h3C with a single rx_valid pulse, and tx_ready returns to 1 at frame start.
- Run a frame with no tx word loaded: MISO shifts 8'h00 and tx_underrun pulses once at ss_n falling.
- Hold ss_n low for two back-to-back frames (tx 8'h81 then 8'h7E written during the first frame, MOSI 8'h12, 8'h34): MISO carries 8'h81 then 8'h7E, and rx_valid pulses twice with 8'h12 then 8'h34.
- Raise ss_n after 5 bits: frame_err pulses, no rx_valid, rx_data keeps its previous value, and miso = 0 within 4 clk.
- Write to the holding register at the same cycle it is consumed at frame start: the old word is transmitted, the new word remains buffered, and tx_ready = 0.
- Assert rst_n low at bit 3, then release with ss_n still low: all outputs are at reset values and no rx_valid occurs until a new ss_n falling edge.
